dcc_ce_seq: RTL and testbench
=============================

DCC_CE_SEQ -- requirements
Module: dcc_ce_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles from a dcc_ce edge to done; legal range 1..255.
REQ-002 SHALL have parameter MIN_HOLD, default 8: minimum cycles dcc_ce stays at a level before the next change; legal range 0..255, 0 means no hold.
REQ-003 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have port req_valid  in  1  request offered.
REQ-006 SHALL have port req_en  in  1  requested dcc_ce level, qualified by req_valid.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port dcc_ce  out  1  registered clock-enable driving the downstream DCC CE pin.
REQ-009 SHALL have port done  out  1  single-cycle pulse when an accepted request has completed.
REQ-010 SHALL have port busy  out  1  high in TURN_ON/TURN_OFF states.

Function
REQ-011 SHALL implement states OFF, TURN_ON, ON, TURN_OFF; OFF/ON are stable.
REQ-012 SHALL accept a request on a cycle with req_valid && req_ready; req_ready = stable state && hold counter == 0, combinational from registers only, never from req_valid.
REQ-013 SHALL, on accept with req_en equal to the current level, stay in the stable state, leave dcc_ce unchanged, and pulse done on the next cycle.
REQ-014 SHALL, on accept in OFF with req_en=1, set dcc_ce=1 on the next edge, enter TURN_ON, load settle counter with SETTLE_CYCLES and hold counter with MIN_HOLD.
REQ-015 SHALL, on accept in ON with req_en=0, behave as REQ-014 mirrored: dcc_ce=0, enter TURN_OFF.
REQ-016 SHALL decrement the settle counter once per cycle in TURN_ON/TURN_OFF; when it reaches 1, next edge enters ON/OFF respectively and pulses done; done therefore follows the dcc_ce edge by exactly SETTLE_CYCLES cycles.
REQ-017 SHALL decrement the hold counter every cycle while non-zero, in any state, saturating at 0.
REQ-018 SHALL change dcc_ce only on the edge following an accept; dcc_ce SHALL never toggle twice within max(SETTLE_CYCLES, MIN_HOLD) cycles.
REQ-019 SHALL ignore req_valid while req_ready is low; req_en need not be held stable by the requester until accept.
REQ-020 SHALL size both counters at 8 bits; counters SHALL never wrap below 0.

Reset
REQ-021 SHALL, when rst is high at an edge, force state OFF, dcc_ce=0, done=0, busy=0, both counters 0, so req_ready=1 the cycle after reset release.
REQ-022 SHALL give rst priority over any request, including reset mid-TURN_ON: dcc_ce drops to 0 on that edge and no done pulse is produced.

Configuration
REQ-023 SHALL recognise macro DCC_CE_SEQ_TOGGLE_CNT_EN.
REQ-024 SHALL, with DCC_CE_SEQ_TOGGLE_CNT_EN defined, add output toggle_cnt (16 bits) counting dcc_ce edges, saturating at 16'hFFFF, cleared by rst.
REQ-025 SHALL, without the macro, omit the port and its logic entirely; all other behaviour identical.

Structure
REQ-026 SHALL place the state enum (2 bits) and the counter width constant (8) in package dcc_ce_seq_pkg.
REQ-027 SHALL instantiate sub-module dcc_hold_timer (load, load value, saturating down-count, zero flag) twice: settle and hold counters.

Verification
REQ-028 Reset then req_valid=1, req_en=1 at cycle 0 -> dcc_ce=1 at cycle 1, done pulse at cycle 5, busy high cycles 1-4 (defaults).
REQ-029 In ON, request req_en=1 -> dcc_ce stays 1, done at next cycle, no busy.
REQ-030 ON at cycle 0 with MIN_HOLD=8, SETTLE_CYCLES=4; req_valid held with req_en=0 -> req_ready low until hold expires, accept at cycle 8, dcc_ce=0 at cycle 9.
REQ-031 Assert rst at cycle 2 of TURN_ON -> dcc_ce=0 next edge, no done, req_ready=1 after release.
REQ-032 MIN_HOLD=0, SETTLE_CYCLES=1, back-to-back alternating requests -> dcc_ce toggles every 2 cycles, done each toggle+1.
REQ-033 With DCC_CE_SEQ_TOGGLE_CNT_EN, 3 on/off transitions -> toggle_cnt=3; rst -> 0.

Source files
------------

// File: rtl/dcc_ce_seq_pkg.sv
// dcc_ce_seq_pkg: shared state encoding and counter width for the DCC CE sequencer.
package dcc_ce_seq_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {S_OFF, S_TURN_ON, S_ON, S_TURN_OFF} state_t;
endpackage

// File: rtl/dcc_ce_seq_hold_timer.sv
// dcc_hold_timer: loadable down-counter that saturates at zero and flags it.
module dcc_hold_timer
  import dcc_ce_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= rst ? '0 : i_load ? i_val : (r_cnt == '0) ? r_cnt : r_cnt - CNT_W'(1);
  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/dcc_ce_seq.sv
// dcc_ce_seq: sequences the DCC clock-enable with settle and minimum-hold timing.
// Define DCC_CE_SEQ_TOGGLE_CNT_EN to add the saturating toggle_cnt output.
module dcc_ce_seq
  import dcc_ce_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_HOLD      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_en,
  output logic        req_ready,
  output logic        dcc_ce,
  output logic        done,
  output logic        busy
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
  ,
  output logic [15:0] toggle_cnt
`endif
);
  state_t r_state;
  logic r_dcc_ce, r_done;
  logic w_stable, w_busy, w_acc, w_chg, w_settle_end, w_settle_zero, w_hold_zero;
  logic [CNT_W-1:0] w_settle_cnt, w_unused_hold_cnt;
  assign w_stable  = (r_state == S_OFF) || (r_state == S_ON);
  assign w_busy    = !w_stable;
  assign req_ready = w_stable && w_hold_zero;
  assign w_acc     = req_valid && req_ready;
  assign w_chg     = w_acc && (req_en != r_dcc_ce);
  // zero is a fallback so a transition state can never get stuck
  assign w_settle_end = (w_settle_cnt == CNT_W'(1)) || w_settle_zero;
  dcc_hold_timer u_settle (
    .clk(clk), .rst(rst), .i_load(w_chg), .i_val(CNT_W'(SETTLE_CYCLES)),
    .o_cnt(w_settle_cnt), .o_zero(w_settle_zero)
  );
  dcc_hold_timer u_hold (
    .clk(clk), .rst(rst), .i_load(w_chg), .i_val(CNT_W'(MIN_HOLD)),
    .o_cnt(w_unused_hold_cnt), .o_zero(w_hold_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= S_OFF;
      r_dcc_ce <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_dcc_ce <= w_chg ? req_en : r_dcc_ce;
      r_done   <= (w_acc && !w_chg) || (w_busy && w_settle_end);
      r_state  <= w_chg ? (req_en ? S_TURN_ON : S_TURN_OFF)
                : (w_busy && w_settle_end) ? ((r_state == S_TURN_ON) ? S_ON : S_OFF)
                : r_state;
    end
  assign dcc_ce = r_dcc_ce;
  assign done   = r_done;
  assign busy   = w_busy;
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
  logic [15:0] r_toggle_cnt;
  always_ff @(posedge clk)
    r_toggle_cnt <= rst ? '0 : (w_chg && r_toggle_cnt != 16'hFFFF) ? r_toggle_cnt + 16'd1 : r_toggle_cnt;
  assign toggle_cnt = r_toggle_cnt;
`endif
endmodule

// File: tb/tb_dcc_ce_seq.sv
// tb_dcc_ce_seq: table vectors, corner sequences and randomized run against a timing model.
module tb_dcc_ce_seq;
  localparam int S = 4, H = 8;
  localparam int HS = (H > S) ? H : S;
  logic clk = 1'b0;
  logic rst, v, e, rdy, ce, dn, bsy;
  logic rst2, v2, e2, rdy2, ce2, dn2, bsy2;
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
  logic [15:0] tc, tc2;
`endif
  int checks = 0, errors = 0;
  int t, last_chg, last_same, toggles;
  logic level;

  typedef struct packed { logic v, e, rdy, ce, dn, bsy; } vec_t;
  vec_t tbl[$];

  dcc_ce_seq #(.SETTLE_CYCLES(S), .MIN_HOLD(H)) u_dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_en(e), .req_ready(rdy),
    .dcc_ce(ce), .done(dn), .busy(bsy)
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
    , .toggle_cnt(tc)
`endif
  );
  dcc_ce_seq #(.SETTLE_CYCLES(1), .MIN_HOLD(0)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid(v2), .req_en(e2), .req_ready(rdy2),
    .dcc_ce(ce2), .done(dn2), .busy(bsy2)
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
    , .toggle_cnt(tc2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_reset;
    last_chg = -1000; last_same = -1000; level = 1'b0; toggles = 0; t = 0;
  endtask

  // Model in terms of event times: dcc_ce moves the cycle after a changing accept,
  // busy spans SETTLE_CYCLES, and the next accept waits max(SETTLE, HOLD)+1 cycles.
  task automatic step(input logic vi, input logic ei);
    logic m_rdy;
    m_rdy = (t >= last_chg + 1 + HS);
    chk("req_ready", rdy, m_rdy);
    chk("dcc_ce", ce, level);
    chk("done", dn, (t == last_chg + S + 1) || (t == last_same + 1));
    chk("busy", bsy, (t >= last_chg + 1) && (t <= last_chg + S));
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
    chk("toggle_cnt", tc, toggles);
`endif
    if (vi && m_rdy) begin
      if (ei != level) begin last_chg = t; level = ei; toggles++; end
      else last_same = t;
    end
    v = vi; e = ei;
    @(posedge clk); #1; t++;
  endtask

  task automatic do_reset;
    rst = 1'b1; v = 1'b0; e = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl = '{6'b111000, 6'b100101, 6'b000101, 6'b000101, 6'b000101,
            6'b100110, 6'b000100, 6'b000100, 6'b000100, 6'b111100,
            6'b101110, 6'b000001, 6'b000001, 6'b000001, 6'b000001,
            6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b001000};
    rst2 = 1'b1; v2 = 1'b0; e2 = 1'b0;
    do_reset();
    rst2 = 1'b0;
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d ready", i), rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d dcc_ce", i), ce, tbl[i].ce);
      chk($sformatf("tbl%0d done", i), dn, tbl[i].dn);
      chk($sformatf("tbl%0d busy", i), bsy, tbl[i].bsy);
      v = tbl[i].v; e = tbl[i].e;
      @(posedge clk); #1; t++;
    end

    // reset two cycles into TURN_ON while a request is offered
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    rst = 1'b1; v = 1'b1; e = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (8) step(1'b0, 1'b0);

    // reset wins over an acceptable request in OFF
    rst = 1'b1; v = 1'b1; e = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; v = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0);

    // back-to-back alternating requests with SETTLE=1, HOLD=0
    for (int k = 0; k < 10; k++) begin
      logic xl;
      xl = ((k + 1) >> 1) & 1;
      chk($sformatf("fast%0d dcc_ce", k), ce2, xl);
      chk($sformatf("fast%0d done", k), dn2, (k >= 2) && (k % 2 == 0));
      chk($sformatf("fast%0d ready", k), rdy2, (k % 2 == 0));
      v2 = 1'b1; e2 = !xl;
      @(posedge clk); #1;
    end
    v2 = 1'b0;
`ifdef DCC_CE_SEQ_TOGGLE_CNT_EN
    chk("fast toggle_cnt", tc2, 5);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("fast toggle_cnt rst", tc2, 0);
`endif

    do_reset();
    repeat (900) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
